param_pipeline_processor: RTL and testbench

//  Parametrised 4-stage (IF, ID, EX, WB) in-order processor core, next generation of the 8-bit 3-op core.

---
 rtl/param_pipeline_processor.sv | 234 +++++++++++++++++++++++
 tb/tb_param_pipeline_processor.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_pipeline_processor.sv
// Parametrised 4-stage (IF, ID, EX, WB) in-order core with separate instruction/data memories and a start/halt FSM.
// Optional feature macro: FORWARD_EN (EX/WB->EX and WB->ID operand bypass).
module param_pipeline_processor #(
    parameter  int DATA_W     = 8,
    parameter  int NREG       = 4,
    parameter  int IMEM_DEPTH = 16,
    parameter  int DMEM_DEPTH = 16,
    localparam int RAW        = $clog2(NREG),
    localparam int IW         = 3 + 3 * RAW,
    localparam int IAW        = $clog2(IMEM_DEPTH),
    localparam int DAW        = $clog2(DMEM_DEPTH),
    localparam int AW         = (IAW > DAW) ? IAW : DAW,
    localparam int PW         = (IW > DATA_W) ? IW : DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prog_we,
    input  logic              prog_sel,
    input  logic [AW-1:0]     prog_addr,
    input  logic [PW-1:0]     prog_wdata,
    input  logic [RAW-1:0]    dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [IAW-1:0]    pc,
    output logic              busy,
    output logic              halted,
    output logic              wb_valid,
    output logic [RAW-1:0]    wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_LOAD = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_NOP  = 3'd6,
        OP_HALT = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e              state_r, state_nxt_s;
    logic [IAW-1:0]      pc_r;
    logic [IW-1:0]       imem_r [IMEM_DEPTH];
    logic [DATA_W-1:0]   dmem_r [DMEM_DEPTH];
    logic [DATA_W-1:0]   regs_r [NREG];
    logic [15:0]         retired_r;

    logic                if_id_valid_r;
    logic [IW-1:0]       if_id_instr_r;
    logic                id_ex_valid_r;
    op_e                 id_ex_op_r;
    logic [RAW-1:0]      id_ex_rd_r;
    logic [DATA_W-1:0]   id_ex_a_r, id_ex_b_r;
`ifdef FORWARD_EN
    logic [RAW-1:0]      id_ex_rs1_r, id_ex_rs2_r;
`endif
    logic                ex_wb_valid_r;
    logic [RAW-1:0]      ex_wb_rd_r;
    logic [DATA_W-1:0]   ex_wb_data_r;

    op_e                 id_op_s;
    logic [RAW-1:0]      id_rd_s, id_rs1_s, id_rs2_s;
    logic                id_writes_s, id_halt_s;
    logic [DATA_W-1:0]   id_a_s, id_b_s, ex_a_s, ex_b_s, ex_result_s;
    logic                idle_like_s, start_ok_s;

    assign idle_like_s = (state_r == S_IDLE) || (state_r == S_HALTED);
    assign start_ok_s  = start && idle_like_s;

    // Decode and register read; NOP/HALT become bubbles that never write.
    always_comb begin
        id_op_s     = op_e'(if_id_instr_r[IW-1 -: 3]);
        id_rd_s     = if_id_instr_r[IW-4 -: RAW];
        id_rs1_s    = if_id_instr_r[IW-4-RAW -: RAW];
        id_rs2_s    = if_id_instr_r[RAW-1:0];
        id_writes_s = if_id_valid_r && (id_op_s != OP_NOP) && (id_op_s != OP_HALT);
        id_halt_s   = if_id_valid_r && (id_op_s == OP_HALT);
        id_a_s      = regs_r[id_rs1_s];
        id_b_s      = regs_r[id_rs2_s];
`ifdef FORWARD_EN
        if (ex_wb_valid_r && (ex_wb_rd_r == id_rs1_s)) begin
            id_a_s = ex_wb_data_r;
        end else begin
            id_a_s = regs_r[id_rs1_s];
        end
        if (ex_wb_valid_r && (ex_wb_rd_r == id_rs2_s)) begin
            id_b_s = ex_wb_data_r;
        end else begin
            id_b_s = regs_r[id_rs2_s];
        end
`endif
    end

    // Execute: operand bypass from EX/WB (when enabled) and ALU / data-memory read.
    always_comb begin
        ex_a_s      = id_ex_a_r;
        ex_b_s      = id_ex_b_r;
        ex_result_s = {DATA_W{1'b0}};
`ifdef FORWARD_EN
        if (ex_wb_valid_r && (ex_wb_rd_r == id_ex_rs1_r)) begin
            ex_a_s = ex_wb_data_r;
        end else begin
            ex_a_s = id_ex_a_r;
        end
        if (ex_wb_valid_r && (ex_wb_rd_r == id_ex_rs2_r)) begin
            ex_b_s = ex_wb_data_r;
        end else begin
            ex_b_s = id_ex_b_r;
        end
`endif
        case (id_ex_op_r)
            OP_ADD:  ex_result_s = ex_a_s + ex_b_s;
            OP_SUB:  ex_result_s = ex_a_s - ex_b_s;
            OP_LOAD: ex_result_s = dmem_r[ex_a_s[DAW-1:0]];
            OP_AND:  ex_result_s = ex_a_s & ex_b_s;
            OP_OR:   ex_result_s = ex_a_s | ex_b_s;
            OP_XOR:  ex_result_s = ex_a_s ^ ex_b_s;
            default: ex_result_s = {DATA_W{1'b0}};
        endcase
    end

    // Control FSM next-state: DRAIN waits until no writing instruction remains in ID/EX or EX/WB.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_HALTED: begin
                if (start) state_nxt_s = S_RUN;
                else       state_nxt_s = state_r;
            end
            S_RUN: begin
                if (id_halt_s) state_nxt_s = S_DRAIN;
                else           state_nxt_s = S_RUN;
            end
            S_DRAIN: begin
                if (!id_ex_valid_r && !ex_wb_valid_r) state_nxt_s = S_HALTED;
                else                                  state_nxt_s = S_DRAIN;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Fetch and pipeline registers; an accepted start restarts at address 0 with an empty pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= {IAW{1'b0}};
            if_id_valid_r <= 1'b0;
            if_id_instr_r <= {IW{1'b0}};
            id_ex_valid_r <= 1'b0;
            id_ex_op_r    <= OP_NOP;
            id_ex_rd_r    <= {RAW{1'b0}};
            id_ex_a_r     <= {DATA_W{1'b0}};
            id_ex_b_r     <= {DATA_W{1'b0}};
`ifdef FORWARD_EN
            id_ex_rs1_r   <= {RAW{1'b0}};
            id_ex_rs2_r   <= {RAW{1'b0}};
`endif
            ex_wb_valid_r <= 1'b0;
            ex_wb_rd_r    <= {RAW{1'b0}};
            ex_wb_data_r  <= {DATA_W{1'b0}};
        end else if (start_ok_s) begin
            pc_r          <= {IAW{1'b0}};
            if_id_valid_r <= 1'b0;
            id_ex_valid_r <= 1'b0;
            ex_wb_valid_r <= 1'b0;
        end else begin
            if ((state_r == S_RUN) && !id_halt_s) begin
                if_id_valid_r <= 1'b1;
                if_id_instr_r <= imem_r[pc_r];
                pc_r          <= pc_r + IAW'(1);
            end else begin
                if_id_valid_r <= 1'b0;
            end
            id_ex_valid_r <= id_writes_s;
            id_ex_op_r    <= id_op_s;
            id_ex_rd_r    <= id_rd_s;
            id_ex_a_r     <= id_a_s;
            id_ex_b_r     <= id_b_s;
`ifdef FORWARD_EN
            id_ex_rs1_r   <= id_rs1_s;
            id_ex_rs2_r   <= id_rs2_s;
`endif
            ex_wb_valid_r <= id_ex_valid_r;
            ex_wb_rd_r    <= id_ex_rd_r;
            ex_wb_data_r  <= ex_result_s;
        end
    end

    // Write-back into the register file and retire counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_r[i] <= {DATA_W{1'b0}};
            retired_r <= 16'd0;
        end else if (ex_wb_valid_r) begin
            regs_r[ex_wb_rd_r] <= ex_wb_data_r;
            retired_r          <= retired_r + 16'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    // Program port: memories are never reset and only accept writes while the core is stopped.
    always_ff @(posedge clk) begin
        if (prog_we && idle_like_s) begin
            if (prog_sel) dmem_r[prog_addr[DAW-1:0]] <= prog_wdata[DATA_W-1:0];
            else          imem_r[prog_addr[IAW-1:0]] <= prog_wdata[IW-1:0];
        end
    end

    assign dbg_rdata = regs_r[dbg_raddr];
    assign pc        = pc_r;
    assign busy      = (state_r == S_RUN) || (state_r == S_DRAIN);
    assign halted    = (state_r == S_HALTED);
    assign wb_valid  = ex_wb_valid_r;
    assign wb_rd     = ex_wb_rd_r;
    assign wb_data   = ex_wb_data_r;
    assign retired   = retired_r;

endmodule

// File: tb/tb_param_pipeline_processor.sv
// Self-checking bench for param_pipeline_processor (DATA_W=8, NREG=4); reference model derives results
// from architectural execution plus a register-visibility window (FORWARD_EN selects the window).
module tb_param_pipeline_processor;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [8:0] I_NOP  = 9'h180;
    localparam logic [8:0] I_HALT = 9'h1C0;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, prog_we = 1'b0, prog_sel = 1'b0;
    logic [3:0]  prog_addr = 4'd0;
    logic [8:0]  prog_wdata = 9'd0;
    logic [1:0]  dbg_raddr = 2'd0;
    logic [7:0]  dbg_rdata, wb_data;
    logic [3:0]  pc;
    logic        busy, halted, wb_valid;
    logic [1:0]  wb_rd;
    logic [15:0] retired;

    int n_cmp = 0, n_fail = 0;

    logic [8:0]  m_imem [16];
    logic [7:0]  m_dmem [16];
    logic [7:0]  m_regs [4];
    logic [7:0]  run_regs [4];
    logic [15:0] m_retired;
    bit          w_en [16];
    logic [1:0]  w_rd [16];
    logic [7:0]  w_val [16];
    bit          ev_valid [64];
    logic [1:0]  ev_rd [64];
    logic [7:0]  ev_data [64];

    param_pipeline_processor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_sel(prog_sel),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .pc(pc), .busy(busy), .halted(halted), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A register read by instruction j sees writes from instructions i<j that are close enough to be visible.
    function automatic logic [7:0] model_read(input logic [1:0] r, input int j);
        logic [7:0] v;
        v = run_regs[r];
        for (int i = 0; i < j; i++)
            if (w_en[i] && w_rd[i] == r && (FWD || (j - i) >= 3)) v = w_val[i];
        return v;
    endfunction

    task automatic model_run();
        logic [2:0] op;
        logic [7:0] a, b, res;
        for (int c = 0; c < 64; c++) ev_valid[c] = 1'b0;
        for (int i = 0; i < 16; i++) w_en[i] = 1'b0;
        run_regs = m_regs;
        for (int j = 0; j < 16; j++) begin
            op = m_imem[j][8:6];
            if (op == 3'd7) break;
            a = model_read(m_imem[j][3:2], j);
            b = model_read(m_imem[j][1:0], j);
            res = 8'd0;
            case (op)
                3'd0: res = a + b;
                3'd1: res = a - b;
                3'd2: res = m_dmem[a[3:0]];
                3'd3: res = a & b;
                3'd4: res = a | b;
                3'd5: res = a ^ b;
                default: res = 8'd0;
            endcase
            if (op != 3'd6) begin
                w_en[j] = 1'b1; w_rd[j] = m_imem[j][5:4]; w_val[j] = res;
                ev_valid[j+3] = 1'b1; ev_rd[j+3] = m_imem[j][5:4]; ev_data[j+3] = res;
                m_regs[m_imem[j][5:4]] = res;
                m_retired = m_retired + 16'd1;
            end
        end
    endtask

    task automatic sync_mem();
        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1; prog_sel = 1'b0; prog_addr = 4'(i); prog_wdata = m_imem[i];
            tick();
            prog_sel = 1'b1; prog_wdata = {1'b0, m_dmem[i]};
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) begin
            m_imem[i] = I_NOP;
            m_dmem[i] = 8'd0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) m_regs[r] = 8'd0;
        m_retired = 16'd0;
    endtask

    // Start, follow the write-back stream cycle by cycle, wait for HALTED, then compare architectural state.
    task automatic run_and_check(input string name, input bit poke);
        bit done;
        model_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b expected 1", name, busy); end
        done = 1'b0;
        for (int c = 1; c < 64 && !done; c++) begin
            if (poke && c == 1) begin
                prog_we = 1'b1; prog_sel = 1'b1; prog_addr = 4'd0; prog_wdata = {1'b0, ~m_dmem[0]};
            end else if (poke && c == 2) begin
                prog_we = 1'b1; prog_sel = 1'b0; prog_addr = 4'd7; prog_wdata = I_HALT;
            end else begin
                prog_we = 1'b0;
            end
            tick();
            n_cmp++;
            if (wb_valid !== ev_valid[c] || (ev_valid[c] && (wb_rd !== ev_rd[c] || wb_data !== ev_data[c]))) begin
                n_fail++;
                $display("FAIL %s_wb@%0d: got v=%b rd=%0d d=%h expected v=%b rd=%0d d=%h",
                         name, c, wb_valid, wb_rd, wb_data, ev_valid[c], ev_rd[c], ev_data[c]);
            end
            if (halted === 1'b1) done = 1'b1;
        end
        prog_we = 1'b0;
        n_cmp++;
        if (!done) begin n_fail++; $display("FAIL %s_halt_timeout: got halted=%b expected 1", name, halted); end
        for (int r = 0; r < 4; r++) begin
            dbg_raddr = 2'(r);
            #1;
            n_cmp++;
            if (dbg_rdata !== m_regs[r]) begin
                n_fail++; $display("FAIL %s_R%0d: got %h expected %h", name, r, dbg_rdata, m_regs[r]);
            end
        end
        n_cmp++;
        if (retired !== m_retired || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_retired: got %0d busy=%b expected %0d busy=0", name, retired, busy, m_retired);
        end
    endtask

    task automatic check_regs(input string name, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_r [4];
        exp_r = '{e0, e1, e2, e3};
        for (int r = 0; r < 4; r++) begin
            dbg_raddr = 2'(r);
            #1;
            n_cmp++;
            if (dbg_rdata !== exp_r[r]) begin
                n_fail++; $display("FAIL %s_R%0d: got %h expected %h", name, r, dbg_rdata, exp_r[r]);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (pc !== 4'd0 || busy !== 1'b0 || halted !== 1'b0 || retired !== 16'd0 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pc=%0d busy=%b halted=%b retired=%0d wbv=%b expected all 0",
                     pc, busy, halted, retired, wb_valid);
        end
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        do_reset();
        fill_nop();
        m_imem[0] = I_HALT;
        sync_mem();
        run_and_check("reset_start", 1'b0);
    endtask

    task automatic test_forward_chain();
        do_reset();
        fill_nop();
        m_dmem[0] = 8'h05;
        m_imem[0] = enc(3'd2, 2'd1, 2'd0, 2'd0);
        m_imem[1] = enc(3'd0, 2'd2, 2'd1, 2'd1);
        m_imem[2] = enc(3'd1, 2'd3, 2'd2, 2'd1);
        m_imem[3] = I_HALT;
        sync_mem();
        run_and_check("chain", 1'b0);
        check_regs("chain_spec", 8'h00, 8'h05, FWD ? 8'h0A : 8'h00, FWD ? 8'h05 : 8'h00);
        n_cmp++;
        if (retired !== 16'd3 || halted !== 1'b1) begin
            n_fail++; $display("FAIL chain_retired: got %0d halted=%b expected 3 halted=1", retired, halted);
        end
    endtask

    task automatic test_nop_spacing();
        do_reset();
        fill_nop();
        m_dmem[0] = 8'h05;
        m_imem[0] = enc(3'd2, 2'd1, 2'd0, 2'd0);
        m_imem[3] = enc(3'd0, 2'd2, 2'd1, 2'd1);
        m_imem[6] = enc(3'd1, 2'd3, 2'd2, 2'd1);
        m_imem[7] = I_HALT;
        sync_mem();
        run_and_check("spaced", 1'b0);
        check_regs("spaced_spec", 8'h00, 8'h05, 8'h0A, 8'h05);
    endtask

    task automatic test_overflow();
        do_reset();
        fill_nop();
        m_dmem[0] = 8'hFF;
        m_imem[0] = enc(3'd2, 2'd1, 2'd0, 2'd0);
        m_imem[1] = enc(3'd0, 2'd2, 2'd1, 2'd1);
        m_imem[2] = enc(3'd1, 2'd3, 2'd0, 2'd1);
        m_imem[3] = enc(3'd5, 2'd0, 2'd1, 2'd2);
        m_imem[4] = I_HALT;
        sync_mem();
        run_and_check("overflow", 1'b0);
`ifdef FORWARD_EN
        check_regs("overflow_spec", 8'h01, 8'hFF, 8'hFE, 8'h01);
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        fill_nop();
        sync_mem();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (pc !== 4'd0) begin n_fail++; $display("FAIL wrap_pc0: got %0d expected 0", pc); end
        for (int c = 1; c <= 17; c++) begin
            tick();
            n_cmp++;
            if (pc !== 4'(c % 16) || retired !== 16'd0 || halted !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_step%0d: got pc=%0d retired=%0d halted=%b busy=%b expected pc=%0d retired=0 halted=0 busy=1",
                         c, pc, retired, halted, busy, c % 16);
            end
        end
        do_reset();
    endtask

    task automatic test_midrun();
        fill_nop();
        m_dmem[0] = 8'h3C;
        m_imem[4] = enc(3'd2, 2'd1, 2'd0, 2'd0);
        m_imem[7] = enc(3'd0, 2'd2, 2'd1, 2'd1);
        m_imem[8] = I_HALT;
        sync_mem();
        run_and_check("poke", 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc !== 4'd0 || busy !== 1'b0 || halted !== 1'b0 || retired !== 16'd0 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got pc=%0d busy=%b halted=%b retired=%0d wbv=%b expected all 0",
                     pc, busy, halted, retired, wb_valid);
        end
        check_regs("midreset", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) m_regs[r] = 8'd0;
        m_retired = 16'd0;
        run_and_check("rerun", 1'b0);
    endtask

    task automatic test_random();
        int h;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 16; i++) begin
                m_imem[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
                m_dmem[i] = 8'($urandom);
            end
            h = $urandom_range(1, 15);
            m_imem[h] = I_HALT;
            sync_mem();
            run_and_check($sformatf("rand%0d", it), 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int r = 0; r < 4; r++) m_regs[r] = 8'd0;
        m_retired = 16'd0;
        test_reset();
        test_forward_chain();
        test_nop_spacing();
        test_wrap();
        test_midrun();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
